// File: rtl/trig_counter_pkg.sv
// trig_counter_pkg
//   Shared definitions for the host-controlled up/down counter:
//   run-state encoding, bit positions inside the `flags` WireOut word,
//   bit positions of the triggers on the TriggerIn endpoint, and the
//   32-bit step helper (wrap or saturate, with overflow/underflow report).
package trig_counter_pkg;

    localparam int CNT_W = 32;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_RUN  = 1'b1
    } state_e;

    // Bit positions inside the 16-bit flags word.
    localparam int FLAG_UNF    = 0;
    localparam int FLAG_OVF    = 1;
    localparam int FLAG_SEQ_LO = 2;
    localparam int FLAG_SEQ_HI = 3;

    // Bit positions of the triggers on the TriggerIn endpoint.
    localparam int TRIG_CLEAR = 0;
    localparam int TRIG_UP    = 1;
    localparam int TRIG_DOWN  = 2;
    localparam int TRIG_RUN   = 3;
    localparam int TRIG_STOP  = 4;
    localparam int TRIG_SNAP  = 5;

    typedef struct packed {
        logic [CNT_W-1:0] value;
        logic             ovf;
        logic             unf;
    } step_t;

    // One unsigned step.
    // Stepping past either end of the range always reports the event.
    // In saturate mode the value stays put at the end of the range.
    function automatic step_t count_step(input logic [CNT_W-1:0] value,
                                         input logic             down,
                                         input logic             sat);
        step_t r;
        r.value = value;
        r.ovf   = 1'b0;
        r.unf   = 1'b0;
        if (!down) begin
            if (value == '1) begin
                r.ovf   = 1'b1;
                r.value = sat ? value : '0;
            end else begin
                r.value = value + CNT_W'(1);
            end
        end else begin
            if (value == '0) begin
                r.unf   = 1'b1;
                r.value = sat ? value : '1;
            end else begin
                r.value = value - CNT_W'(1);
            end
        end
        return r;
    endfunction

endpackage

// File: rtl/tick_gen.sv
// tick_gen
//   Prescaler for the free-running mode. A 32-bit down-counter that emits
//   `tick` in every enabled cycle in which it reads zero, then reloads
//   `prescale`, so ticks come every prescale+1 cycles.
// Ports:
//   sys_clk   clock
//   reset     synchronous, active-high; counter returns to 0
//   en        counting enabled (counter is in RUN)
//   reload    force a reload of `prescale` (run entry, clear)
//   prescale  reload value, sampled only when reloading
//   tick      combinational strobe: en && counter == 0
module tick_gen (
    input  logic        sys_clk,
    input  logic        reset,
    input  logic        en,
    input  logic        reload,
    input  logic [31:0] prescale,
    output logic        tick
);

    logic [31:0] cnt_q, cnt_d;

    assign tick = en && (cnt_q == '0);

    always_comb begin
        // NOTE: assign a default before any branch so every path drives cnt_d; otherwise a latch is inferred.
        cnt_d = cnt_q;
        if (reload || tick) begin
            cnt_d = prescale;
        end else if (en) begin
            cnt_d = cnt_q - 32'd1;
        end
    end

    // NOTE: sequential state uses non-blocking (<=) so every register samples pre-edge values.
    always_ff @(posedge sys_clk) begin
        if (reset) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/trig_updown_counter.sv
// trig_updown_counter
//   Host-controlled 32-bit up/down counter. It takes one-cycle trigger
//   pulses and WireIn levels, and it drives a live count, a coherent
//   16+16 snapshot, sticky flags and an LED activity strobe. There is also
//   a free-running RUN mode, whose step rate the prescaler sets.
// Ports:
//   sys_clk, reset              clock; synchronous active-high reset
//   trig_clear/up/down          zero+clear flags+stop / manual +1 / manual -1
//   trig_run/stop               enter RUN / enter IDLE (stop wins)
//   trig_snap                   capture pre-update count into snapshot
//   direction, sat_mode         RUN direction (1 = down); 1 = saturate
//   prescale                    RUN steps once every prescale+1 cycles
//   count, snap_lo, snap_hi     live count and snapshot halves
//   flags                       {12'd0, snap_seq[1:0], ovf, unf}
//   running, act                in RUN; activity stretch non-zero
module trig_updown_counter
    import trig_counter_pkg::*;
#(
    parameter int ACT_W = 22
) (
    input  logic        sys_clk,
    input  logic        reset,
    input  logic        trig_clear,
    input  logic        trig_up,
    input  logic        trig_down,
    input  logic        trig_run,
    input  logic        trig_stop,
    input  logic        trig_snap,
    input  logic        direction,
    input  logic        sat_mode,
    input  logic [31:0] prescale,
    output logic [31:0] count,
    output logic [15:0] snap_lo,
    output logic [15:0] snap_hi,
    output logic [15:0] flags,
    output logic        running,
    output logic        act
);

    state_e           state_q, state_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic [CNT_W-1:0] snap_q,  snap_d;
    logic [1:0]       seq_q,   seq_d;
    logic             ovf_q,   ovf_d;
    logic             unf_q,   unf_d;
    logic [ACT_W-1:0] stretch_q, stretch_d;
    logic             act_q,   act_d;

    logic  tick;
    logic  reload;
    logic  manual_up, manual_dn;
    logic  do_step, step_down;
    step_t step_res;

    // The prescaler counts only in RUN. It restarts on entry to RUN and on
    // clear. A tick reloads it inside tick_gen, so a tick that a manual
    // step swallows still restarts the period.
    tick_gen u_tick_gen (
        .sys_clk  (sys_clk),
        .reset    (reset),
        .en       (state_q == ST_RUN),
        .reload   (reload),
        .prescale (prescale),
        .tick     (tick)
    );

    always_comb begin
        state_d = state_q;
        if (state_q == ST_RUN) begin
            if (trig_stop || trig_clear) state_d = ST_IDLE;
        end else if (trig_run && !trig_stop && !trig_clear) begin
            state_d = ST_RUN;
        end
        reload = trig_clear || ((state_q == ST_IDLE) && (state_d == ST_RUN));

        // Up and down together cancel as a manual step, so a pending tick
        // still gets applied in that cycle.
        manual_up = trig_up && !trig_down;
        manual_dn = trig_down && !trig_up;
        do_step   = 1'b0;
        step_down = direction;
        if (manual_up || manual_dn) begin
            do_step   = 1'b1;
            step_down = manual_dn;
        end else if (tick) begin
            do_step = 1'b1;
        end
        step_res = count_step(count_q, step_down, sat_mode);

        count_d = count_q;
        ovf_d   = ovf_q;
        unf_d   = unf_q;
        if (trig_clear) begin
            count_d = '0;
            ovf_d   = 1'b0;
            unf_d   = 1'b0;
        end else if (do_step) begin
            count_d = step_res.value;
            ovf_d   = ovf_q | step_res.ovf;
            unf_d   = unf_q | step_res.unf;
        end

        // The snapshot takes the count as it was at the start of the cycle,
        // so a capture together with clear still returns the old value.
        snap_d = snap_q;
        seq_d  = seq_q;
        if (trig_snap) begin
            snap_d = count_q;
            seq_d  = seq_q + 2'd1;
        end

        // Only a real change of value reloads the stretch. A saturated
        // step that holds the count leaves the LED alone.
        if (count_d != count_q) begin
            stretch_d = '1;
        end else if (stretch_q != '0) begin
            stretch_d = stretch_q - ACT_W'(1);
        end else begin
            stretch_d = stretch_q;
        end
        act_d = (stretch_q != '0);
    end

    always_ff @(posedge sys_clk) begin
        if (reset) begin
            state_q   <= ST_IDLE;
            count_q   <= '0;
            snap_q    <= '0;
            seq_q     <= '0;
            ovf_q     <= 1'b0;
            unf_q     <= 1'b0;
            stretch_q <= '0;
            act_q     <= 1'b0;
        end else begin
            state_q   <= state_d;
            count_q   <= count_d;
            snap_q    <= snap_d;
            seq_q     <= seq_d;
            ovf_q     <= ovf_d;
            unf_q     <= unf_d;
            stretch_q <= stretch_d;
            act_q     <= act_d;
        end
    end

    always_comb begin
        flags                          = '0;
        flags[FLAG_UNF]                = unf_q;
        flags[FLAG_OVF]                = ovf_q;
        flags[FLAG_SEQ_HI:FLAG_SEQ_LO] = seq_q;
    end

    assign count   = count_q;
    assign snap_lo = snap_q[15:0];
    assign snap_hi = snap_q[31:16];
    assign running = (state_q == ST_RUN);
    assign act     = act_q;

endmodule

// File: tb/tb_trig_updown_counter.sv
// Self-checking bench for trig_updown_counter. A short activity stretch
// (ACT_W = 4, 15 cycles) lets the LED decay be observed.
module tb_trig_updown_counter;
    import trig_counter_pkg::*;

    localparam logic [5:0] T_NONE = 6'd0;
    localparam logic [5:0] T_CLR  = 6'(1 << TRIG_CLEAR);
    localparam logic [5:0] T_UP   = 6'(1 << TRIG_UP);
    localparam logic [5:0] T_DN   = 6'(1 << TRIG_DOWN);
    localparam logic [5:0] T_RUN  = 6'(1 << TRIG_RUN);
    localparam logic [5:0] T_STOP = 6'(1 << TRIG_STOP);
    localparam logic [5:0] T_SNAP = 6'(1 << TRIG_SNAP);

    logic        sys_clk = 1'b0;
    logic        reset;
    logic [5:0]  trig;
    logic        direction, sat_mode;
    logic [31:0] prescale;
    logic [31:0] count;
    logic [15:0] snap_lo, snap_hi, flags;
    logic        running, act;

    always #5 sys_clk = ~sys_clk;

    trig_updown_counter #(.ACT_W(4)) dut (
        .sys_clk    (sys_clk),
        .reset      (reset),
        .trig_clear (trig[TRIG_CLEAR]),
        .trig_up    (trig[TRIG_UP]),
        .trig_down  (trig[TRIG_DOWN]),
        .trig_run   (trig[TRIG_RUN]),
        .trig_stop  (trig[TRIG_STOP]),
        .trig_snap  (trig[TRIG_SNAP]),
        .direction  (direction),
        .sat_mode   (sat_mode),
        .prescale   (prescale),
        .count      (count),
        .snap_lo    (snap_lo),
        .snap_hi    (snap_hi),
        .flags      (flags),
        .running    (running),
        .act        (act)
    );

    typedef struct {
        string       tag;
        logic [31:0] count;
        logic [15:0] flags;
        logic        running;
    } exp_t;

    typedef struct {
        string       tag;
        logic [5:0]  trig;
        logic        sat;
        logic [31:0] count;
        logic [15:0] flags;
    } vec_t;

    exp_t sb_q[$];
    vec_t tbl[12];
    int   tests = 0;
    int   fails = 0;

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        tests++;
        if (got !== exp) begin
            fails++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h", name, got, exp);
        end
    endtask

    // Called at a falling edge: drive one cycle of stimulus, queue the
    // expected response, then compare it one falling edge later.
    task automatic step(input string tag, input logic [5:0] t, input logic r,
                        input logic [31:0] ec, input logic [15:0] ef, input logic er);
        exp_t e;
        trig  = t;
        reset = r;
        sb_q.push_back('{tag: tag, count: ec, flags: ef, running: er});
        @(posedge sys_clk);
        @(negedge sys_clk);
        trig  = T_NONE;
        reset = 1'b0;
        e = sb_q.pop_front();
        check({e.tag, ".count"},   count,   e.count);
        check({e.tag, ".flags"},   32'(flags), 32'(e.flags));
        check({e.tag, ".running"}, 32'(running), 32'(e.running));
    endtask

    initial begin
        tbl[0]  = '{"up1",       T_UP,        1'b0, 32'd1,        16'h0000};
        tbl[1]  = '{"up2",       T_UP,        1'b0, 32'd2,        16'h0000};
        tbl[2]  = '{"up3",       T_UP,        1'b0, 32'd3,        16'h0000};
        tbl[3]  = '{"down1",     T_DN,        1'b0, 32'd2,        16'h0000};
        tbl[4]  = '{"updown",    T_UP | T_DN, 1'b0, 32'd2,        16'h0000};
        tbl[5]  = '{"clear",     T_CLR,       1'b0, 32'd0,        16'h0000};
        tbl[6]  = '{"wrap_dn",   T_DN,        1'b0, 32'hFFFFFFFF, 16'h0001};
        tbl[7]  = '{"wrap_up",   T_UP,        1'b0, 32'd0,        16'h0003};
        tbl[8]  = '{"wrap_dn2",  T_DN,        1'b0, 32'hFFFFFFFF, 16'h0003};
        tbl[9]  = '{"snap1",     T_SNAP,      1'b0, 32'hFFFFFFFF, 16'h0007};
        tbl[10] = '{"clear2",    T_CLR,       1'b0, 32'd0,        16'h0004};
        tbl[11] = '{"sat_dn",    T_DN,        1'b1, 32'd0,        16'h0005};

        reset = 1'b1; trig = T_NONE; direction = 1'b0; sat_mode = 1'b0; prescale = 32'd0;
        repeat (3) @(posedge sys_clk);
        @(negedge sys_clk);
        reset = 1'b0;
        check("rst.count",   count, 32'd0);
        check("rst.flags",   32'(flags), 32'd0);
        check("rst.running", 32'(running), 32'd0);
        check("rst.act",     32'(act), 32'd0);
        check("rst.snap",    {snap_hi, snap_lo}, 32'd0);

        // Manual stepping, wrap, sticky flags, snapshot sequence.
        for (int i = 0; i < 12; i++) begin
            sat_mode = tbl[i].sat;
            step(tbl[i].tag, tbl[i].trig, 1'b0, tbl[i].count, tbl[i].flags, 1'b0);
        end
        check("tbl.act",     32'(act), 32'd1);
        check("tbl.snap_hi", 32'(snap_hi), 32'h0000FFFF);
        check("tbl.snap_lo", 32'(snap_lo), 32'h0000FFFF);

        // Saturation: a held value must not reload the activity stretch.
        sat_mode = 1'b0;
        step("s_clr",  T_CLR, 1'b0, 32'd0,        16'h0004, 1'b0);
        step("s_dn",   T_DN,  1'b0, 32'hFFFFFFFF, 16'h0005, 1'b0);
        step("s_up",   T_UP,  1'b0, 32'd0,        16'h0007, 1'b0);
        step("s_dn2",  T_DN,  1'b0, 32'hFFFFFFFF, 16'h0007, 1'b0);
        for (int i = 0; i < 20; i++) step("s_idle", T_NONE, 1'b0, 32'hFFFFFFFF, 16'h0007, 1'b0);
        check("s_act_decayed", 32'(act), 32'd0);
        sat_mode = 1'b1;
        step("s_sat_up", T_UP,   1'b0, 32'hFFFFFFFF, 16'h0007, 1'b0);
        step("s_hold1",  T_NONE, 1'b0, 32'hFFFFFFFF, 16'h0007, 1'b0);
        check("s_act1", 32'(act), 32'd0);
        step("s_hold2",  T_NONE, 1'b0, 32'hFFFFFFFF, 16'h0007, 1'b0);
        check("s_act2", 32'(act), 32'd0);

        // RUN with prescale 4: one step every 5 cycles; act lags by two.
        sat_mode = 1'b0; prescale = 32'd4; direction = 1'b0;
        step("r_clr", T_CLR, 1'b0, 32'd0, 16'h0004, 1'b0);
        check("r_act_lag", 32'(act), 32'd0);
        step("r_run", T_RUN, 1'b0, 32'd0, 16'h0004, 1'b1);
        check("r_act_rise", 32'(act), 32'd1);
        for (int k = 1; k <= 25; k++) step("r_tick", T_NONE, 1'b0, 32'(k / 5), 16'h0004, 1'b1);
        step("r_stop", T_STOP, 1'b0, 32'd5, 16'h0004, 1'b0);
        for (int i = 0; i < 8; i++) step("r_frozen", T_NONE, 1'b0, 32'd5, 16'h0004, 1'b0);

        // RUN with prescale 0: manual steps interacting with ticks.
        prescale = 32'd0;
        step("m_run",    T_RUN,       1'b0, 32'd5, 16'h0004, 1'b1);
        step("m_up",     T_UP,        1'b0, 32'd6, 16'h0004, 1'b1);
        step("m_updown", T_UP | T_DN, 1'b0, 32'd7, 16'h0004, 1'b1);
        step("m_tick",   T_NONE,      1'b0, 32'd8, 16'h0004, 1'b1);
        step("m_down",   T_DN,        1'b0, 32'd7, 16'h0004, 1'b1);
        step("m_stop",   T_STOP,      1'b0, 32'd8, 16'h0004, 1'b0);
        step("m_idle",   T_NONE,      1'b0, 32'd8, 16'h0004, 1'b0);

        // Snapshot halves, and snap together with clear.
        step("p_snap", T_SNAP, 1'b0, 32'd8, 16'h0008, 1'b0);
        check("p_snap_hi", 32'(snap_hi), 32'h00000000);
        check("p_snap_lo", 32'(snap_lo), 32'h00000008);
        step("p_clr", T_CLR, 1'b0, 32'd0,        16'h0008, 1'b0);
        step("p_dn",  T_DN,  1'b0, 32'hFFFFFFFF, 16'h0009, 1'b0);
        for (int i = 1; i <= 15; i++) step("p_dnk", T_DN, 1'b0, 32'hFFFFFFFF - 32'(i), 16'h0009, 1'b0);
        prescale = 32'd100;
        step("p_run",     T_RUN,          1'b0, 32'hFFFFFFF0, 16'h0009, 1'b1);
        step("p_snapclr", T_SNAP | T_CLR, 1'b0, 32'd0,        16'h000C, 1'b0);
        check("p_sc_hi", 32'(snap_hi), 32'h0000FFFF);
        check("p_sc_lo", 32'(snap_lo), 32'h0000FFF0);

        // Reset in the middle of RUN.
        prescale = 32'd0;
        step("x_run", T_RUN, 1'b0, 32'd0, 16'h000C, 1'b1);
        for (int i = 1; i <= 7; i++) step("x_cnt", T_NONE, 1'b0, 32'(i), 16'h000C, 1'b1);
        step("x_reset", T_NONE, 1'b1, 32'd0, 16'h0000, 1'b0);
        step("x_after", T_NONE, 1'b0, 32'd0, 16'h0000, 1'b0);
        check("x_act", 32'(act), 32'd0);
        step("x_idle", T_NONE, 1'b0, 32'd0, 16'h0000, 1'b0);

        // RUN downward with prescale 1: wraps below zero and sets unf.
        direction = 1'b1; prescale = 32'd1;
        step("d_run", T_RUN, 1'b0, 32'd0, 16'h0000, 1'b1);
        for (int k = 1; k <= 4; k++)
            step("d_tick", T_NONE, 1'b0, 32'd0 - 32'(k / 2), (k >= 2) ? 16'h0001 : 16'h0000, 1'b1);
        step("d_stop", T_STOP, 1'b0, 32'hFFFFFFFE, 16'h0001, 1'b0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
